unpatchifier: RTL and testbench

Reassembles a stream of patch-ordered pixels into a raster-ordered image stream. It is the inverse of the patchifier stage and sits on the output side of the vision-transformer datapath. Input pixels arrive one per cycle over a valid/ready handshake, in patch-major order (patch index, then position within the patch). Once a full frame is buffered internally, it is emitted row by row over a second valid/ready handshake.

---
 rtl/vit_pkg.sv | 29 ++
 rtl/patch_addr_gen.sv | 85 ++++++++
 rtl/unpatchifier.sv | 135 +++++++++++++
 tb/tb_unpatchifier.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// Shared definitions for the vision-transformer patch datapath:
// patch FSM state type, pixel/image defaults and small elaboration helpers.
package vit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        DRAIN = 2'b10
    } patch_state_t;

    localparam int unsigned DEF_CHANNEL_SIZE    = 8;
    localparam int unsigned DEF_NUM_CHANNELS    = 3;
    localparam int unsigned DEF_PIXEL_WIDTH     = DEF_CHANNEL_SIZE * DEF_NUM_CHANNELS;
    localparam int unsigned DEF_IMG_WIDTH       = 64;
    localparam int unsigned DEF_IMG_HEIGHT      = 64;
    localparam int unsigned DEF_PATCH_SIZE      = 16;
    localparam int unsigned DEF_PATCHES_IN_ROW  = DEF_IMG_WIDTH / DEF_PATCH_SIZE;
    localparam int unsigned DEF_PATCH_SIZE_LOG2 = $clog2(DEF_PATCH_SIZE);

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/patch_addr_gen.sv
// Patch-major address sequencer: walks pixels within a patch, then patches
// along a patch-row, then patch-rows, and reports the raster (row, col).
module patch_addr_gen import vit_pkg::*; #(
    parameter int unsigned PATCH_SIZE     = DEF_PATCH_SIZE,
    parameter int unsigned PATCHES_IN_ROW = DEF_PATCHES_IN_ROW,
    parameter int unsigned PATCHES_IN_COL = DEF_IMG_HEIGHT / DEF_PATCH_SIZE,
    parameter int unsigned ROW_W          = clog2_min1(DEF_IMG_HEIGHT),
    parameter int unsigned COL_W          = clog2_min1(DEF_IMG_WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    localparam int unsigned LOG2   = $clog2(PATCH_SIZE);
    localparam int unsigned POS_W  = clog2_min1(PATCH_SIZE);
    localparam int unsigned PCOL_W = clog2_min1(PATCHES_IN_ROW);
    localparam int unsigned PROW_W = clog2_min1(PATCHES_IN_COL);

    localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(PATCH_SIZE - 1);
    localparam logic [PCOL_W-1:0] PCOL_MAX = PCOL_W'(PATCHES_IN_ROW - 1);
    localparam logic [PROW_W-1:0] PROW_MAX = PROW_W'(PATCHES_IN_COL - 1);

    logic [POS_W-1:0]  pos_col_q,   pos_col_d;
    logic [POS_W-1:0]  pos_row_q,   pos_row_d;
    logic [PCOL_W-1:0] patch_col_q, patch_col_d;
    logic [PROW_W-1:0] patch_row_q, patch_row_d;

    // Four-level carry chain, innermost pos_col, outermost patch_row.
    always_comb begin
        pos_col_d   = pos_col_q;
        pos_row_d   = pos_row_q;
        patch_col_d = patch_col_q;
        patch_row_d = patch_row_q;
        if (clear) begin
            pos_col_d   = '0;
            pos_row_d   = '0;
            patch_col_d = '0;
            patch_row_d = '0;
        end else if (step) begin
            if (pos_col_q != POS_MAX) begin
                pos_col_d = pos_col_q + 1'b1;
            end else begin
                pos_col_d = '0;
                if (pos_row_q != POS_MAX) begin
                    pos_row_d = pos_row_q + 1'b1;
                end else begin
                    pos_row_d = '0;
                    if (patch_col_q != PCOL_MAX) begin
                        patch_col_d = patch_col_q + 1'b1;
                    end else begin
                        patch_col_d = '0;
                        patch_row_d = (patch_row_q == PROW_MAX) ? '0 : patch_row_q + 1'b1;
                    end
                end
            end
        end
    end

    // Counter registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_col_q   <= '0;
            pos_row_q   <= '0;
            patch_col_q <= '0;
            patch_row_q <= '0;
        end else begin
            pos_col_q   <= pos_col_d;
            pos_row_q   <= pos_row_d;
            patch_col_q <= patch_col_d;
            patch_row_q <= patch_row_d;
        end
    end

    // PATCH_SIZE is a power of 2, so patch offsets are pure shifts.
    assign row  = (ROW_W'(patch_row_q) << LOG2) | ROW_W'(pos_row_q);
    assign col  = (COL_W'(patch_col_q) << LOG2) | COL_W'(pos_col_q);
    assign last = (pos_col_q == POS_MAX) && (pos_row_q == POS_MAX) &&
                  (patch_col_q == PCOL_MAX) && (patch_row_q == PROW_MAX);

endmodule

// File: rtl/unpatchifier.sv
// Buffers one frame of patch-ordered pixels and replays it in raster order.
module unpatchifier import vit_pkg::*; #(
    parameter int unsigned CHANNEL_SIZE   = DEF_CHANNEL_SIZE,
    parameter int unsigned NUM_CHANNELS   = DEF_NUM_CHANNELS,
    parameter int unsigned PIXEL_WIDTH    = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int unsigned IMG_WIDTH      = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT     = DEF_IMG_HEIGHT,
    parameter int unsigned PATCH_SIZE     = DEF_PATCH_SIZE,
    parameter int unsigned PATCHES_IN_ROW = IMG_WIDTH / PATCH_SIZE,
    parameter int unsigned NUM_PIXELS     = IMG_WIDTH * IMG_HEIGHT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic                   out_last,
    output logic [1:0]             state
);

    localparam int unsigned ROW_W = clog2_min1(IMG_HEIGHT);
    localparam int unsigned COL_W = clog2_min1(IMG_WIDTH);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);

    if (!is_pow2(PATCH_SIZE)) begin : g_chk_patch_pow2
        $error("unpatchifier: PATCH_SIZE must be a power of 2");
    end
    if ((IMG_WIDTH % PATCH_SIZE) != 0 || (IMG_HEIGHT % PATCH_SIZE) != 0) begin : g_chk_divide
        $error("unpatchifier: image dimensions must be multiples of PATCH_SIZE");
    end
    if (NUM_PIXELS != IMG_WIDTH * IMG_HEIGHT || PIXEL_WIDTH < CHANNEL_SIZE * NUM_CHANNELS) begin : g_chk_derived
        $error("unpatchifier: inconsistent derived parameters");
    end

    patch_state_t      state_q, state_d;
    logic [ROW_W-1:0]  out_row_q, out_row_d;
    logic [COL_W-1:0]  out_col_q, out_col_d;
    logic [ROW_W-1:0]  fill_row;
    logic [COL_W-1:0]  fill_col;
    logic              fill_last;
    logic              addr_clear;
    logic              in_fire;
    logic              out_fire;
    logic [PIXEL_WIDTH-1:0] frame_q [IMG_HEIGHT][IMG_WIDTH];

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = out_valid && (out_row_q == ROW_MAX) && (out_col_q == COL_MAX);
    assign state     = state_q;

    patch_addr_gen #(
        .PATCH_SIZE     (PATCH_SIZE),
        .PATCHES_IN_ROW (PATCHES_IN_ROW),
        .PATCHES_IN_COL (IMG_HEIGHT / PATCH_SIZE),
        .ROW_W          (ROW_W),
        .COL_W          (COL_W)
    ) u_addr (
        .clk   (clk),
        .reset (reset),
        .clear (addr_clear),
        .step  (in_fire),
        .row   (fill_row),
        .col   (fill_col),
        .last  (fill_last)
    );

    // Next-state and raster read counters.
    always_comb begin
        state_d    = state_q;
        out_row_d  = out_row_q;
        out_col_d  = out_col_q;
        addr_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d    = FILL;
                    addr_clear = 1'b1;
                    out_row_d  = '0;
                    out_col_d  = '0;
                end
            end
            FILL: begin
                if (in_fire && fill_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (out_fire) begin
                    if (out_col_q != COL_MAX) begin
                        out_col_d = out_col_q + 1'b1;
                    end else begin
                        out_col_d = '0;
                        if (out_row_q != ROW_MAX) begin
                            out_row_d = out_row_q + 1'b1;
                        end else begin
                            out_row_d = '0;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and raster counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    // Frame buffer write; contents are don't-care until refilled, so no reset.
    always_ff @(posedge clk) begin
        if (in_fire) frame_q[fill_row][fill_col] <= in_pixel;
    end

    // Zero-latency raster read, gated to zero outside DRAIN.
    always_comb begin
        out_pixel = '0;
        if (out_valid) out_pixel = frame_q[out_row_q][out_col_q];
    end

endmodule

// File: tb/tb_unpatchifier.sv
module tb_unpatchifier;

    localparam int unsigned W    = 8;
    localparam int unsigned H    = 8;
    localparam int unsigned PS   = 4;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned PW   = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pixel;
    logic          out_last;
    logic [1:0]    state;

    always #5 clk = ~clk;

    unpatchifier #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PATCH_SIZE (PS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_last  (out_last),
        .state     (state)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [PW-1:0] src   [NPIX];
    logic [PW-1:0] exp_q [NPIX];

    // Raster positions/values quoted for the 0..63 pattern frame.
    int unsigned lit_idx [7] = '{0, 1, 4, 8, 12, 62, 63};
    int unsigned lit_val [7] = '{0, 1, 16, 4, 20, 62, 63};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: beat k belongs to patch k/P^2, position k%P^2; patches are
    // laid out left-to-right, top-to-bottom.
    function automatic void build_expected();
        for (int k = 0; k < NPIX; k++) begin
            int patch = k / (PS * PS);
            int pos   = k % (PS * PS);
            int r     = (patch / (W / PS)) * PS + pos / PS;
            int c     = (patch % (W / PS)) * PS + pos % PS;
            exp_q[r * W + c] = src[k];
        end
    endfunction

    function automatic void load_pattern(input int unsigned base);
        for (int k = 0; k < NPIX; k++) src[k] = PW'(base + k);
        build_expected();
    endfunction

    function automatic void load_random();
        for (int k = 0; k < NPIX; k++) src[k] = PW'($urandom);
        build_expected();
    endfunction

    // in_mode: 0 always valid, 1 toggling 1010..., 2 random
    // out_mode: 0 always ready, 1 three stall cycles at raster index 10, 2 random
    task automatic run_frame(input int in_mode, input int out_mode, input bit noise,
                             input bit lits, input bit chk_period);
        int  cycles = 0;
        int  acc    = 0;
        int  idx    = 0;
        int  guard  = 0;
        int  stall  = 0;
        bit  flip   = 1'b1;
        bit  v;
        bit  r;

        check_eq("idle_state", 32'(state), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready), 32'd0);
        en = 1'b1;
        tick();
        en = 1'b0;
        cycles++;
        check_eq("fill_state", 32'(state), 32'd1);

        while (acc < int'(NPIX) && guard < 2000) begin
            check_eq($sformatf("fill_in_ready[%0d]", acc), 32'(in_ready), 32'd1);
            case (in_mode)
                0:       v = 1'b1;
                1: begin v = flip; flip = !flip; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            in_valid = v;
            in_pixel = v ? src[acc] : PW'($urandom);
            if (noise) en = 1'($urandom_range(0, 1));
            tick();
            cycles++;
            guard++;
            if (v) acc++;
        end
        if (acc < int'(NPIX)) check_eq("fill_timeout", 32'(acc), NPIX);
        in_valid = 1'b0;
        en       = 1'b0;

        check_eq("drain_state", 32'(state), 32'd2);
        guard = 0;
        while (idx < int'(NPIX) && guard < 2000) begin
            check_eq($sformatf("out_valid[%0d]", idx), 32'(out_valid), 32'd1);
            check_eq($sformatf("out_pixel[%0d]", idx), 32'(out_pixel), 32'(exp_q[idx]));
            check_eq($sformatf("out_last[%0d]", idx), 32'(out_last), 32'(idx == int'(NPIX) - 1));
            check_eq($sformatf("drain_in_ready[%0d]", idx), 32'(in_ready), 32'd0);
            if (lits) begin
                for (int i = 0; i < 7; i++)
                    if (lit_idx[i] == idx) check_eq($sformatf("lit_pixel[%0d]", idx), 32'(out_pixel), lit_val[i]);
            end
            case (out_mode)
                0: r = 1'b1;
                1: begin
                    if (idx == 10 && stall < 3) begin r = 1'b0; stall++; end
                    else r = 1'b1;
                end
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (noise) begin
                en       = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_pixel = PW'($urandom);
            end
            tick();
            cycles++;
            guard++;
            if (r) idx++;
        end
        if (idx < int'(NPIX)) check_eq("drain_timeout", 32'(idx), NPIX);
        en        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        check_eq("end_state", 32'(state), 32'd0);
        check_eq("end_out_valid", 32'(out_valid), 32'd0);
        check_eq("end_out_pixel", 32'(out_pixel), 32'd0);
        check_eq("end_out_last", 32'(out_last), 32'd0);
        if (chk_period) check_eq("frame_period", 32'(cycles), 32'(2 * NPIX + 1));
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pixel", 32'(out_pixel), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // in_valid in IDLE is not consumed and does not start a frame
        in_valid = 1'b1;
        in_pixel = 24'hABCDEF;
        tick();
        tick();
        check_eq("idle_ignore_state", 32'(state), 32'd0);
        check_eq("idle_ignore_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // basic reorder, then a back-to-back second frame offset by 64
        load_pattern(0);
        run_frame(0, 0, 1'b0, 1'b1, 1'b1);
        load_pattern(64);
        run_frame(0, 0, 1'b0, 1'b0, 1'b1);

        // input backpressure, output backpressure, ignored en/in_valid
        load_pattern(0);
        run_frame(1, 0, 1'b0, 1'b1, 1'b0);
        run_frame(0, 1, 1'b0, 1'b1, 1'b0);
        run_frame(0, 0, 1'b1, 1'b1, 1'b1);

        // reset mid-FILL after 20 beats
        load_random();
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_pixel = src[k];
            tick();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("midfill_rst_state", 32'(state), 32'd0);
        check_eq("midfill_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("midfill_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        load_pattern(0);
        run_frame(0, 0, 1'b0, 1'b1, 1'b1);

        // randomized frames with random handshakes
        for (int f = 0; f < 4; f++) begin
            load_random();
            run_frame(2, 2, 1'b1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
